sampler_trigger: RTL and testbench

SAMPLER_TRIGGER -- requirements
Module: sampler_trigger

---
 rtl/sampler_trigger.sv | 121 ++++++++++++
 tb/tb_sampler_trigger.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sampler_trigger.sv
// Trigger/arming controller for a capture sampler: matches a masked compare on the live bus,
// applies an optional post-trigger holdoff, then enables sampler writes until the sampler reports done.
module sampler_trigger #(
    parameter int width     = 32,
    parameter int delayBits = 16
) (
    input  logic                 w_clk,
    input  logic                 w_reset_n,
    input  logic [width-1:0]     w_in_i,
    input  logic                 arm_i,
    input  logic                 abort_i,
    input  logic                 force_i,
    input  logic [width-1:0]     trig_mask_i,
    input  logic [width-1:0]     trig_value_i,
    input  logic                 trig_edge_i,
    input  logic [delayBits-1:0] trig_delay_i,
    input  logic                 s_done_i,
    output logic                 s_enable_o,
    output logic [2:0]           state_o,
    output logic                 triggered_o,
    output logic                 done_pulse_o,
    output logic [31:0]          wait_count_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        HOLDOFF = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_e;

    state_e               state_q;
    logic                 s_enable_q;
    logic                 triggered_q;
    logic                 done_pulse_q;
    logic [31:0]          wait_count_q;
    logic [31:0]          wait_count_d;
    logic                 prev_match_q;
    logic [delayBits-1:0] delay_cnt_q;
    logic                 match;
    logic                 fire;

    assign match = ((w_in_i ^ trig_value_i) & trig_mask_i) == '0;

    // prev_match_q resets to 1 so an edge trigger never fires on a match already present at arm.
    assign fire = force_i || (match && (!trig_edge_i || !prev_match_q));

    assign wait_count_d = (wait_count_q == 32'hFFFF_FFFF) ? wait_count_q : wait_count_q + 32'd1;

    // NOTE: all state lives in one clocked block with non-blocking assignments, so every
    // register reads the pre-edge value of its peers and the evaluation order does not matter.
    always_ff @(posedge w_clk) begin
        if (!w_reset_n) begin
            state_q      <= IDLE;
            s_enable_q   <= 1'b0;
            triggered_q  <= 1'b0;
            done_pulse_q <= 1'b0;
            wait_count_q <= '0;
            prev_match_q <= 1'b1;
            delay_cnt_q  <= '0;
        end else begin
            done_pulse_q <= 1'b0;
            if (abort_i) begin
                state_q    <= IDLE;
                s_enable_q <= 1'b0;
            end else begin
                case (state_q)
                    // s_enable_q simply holds: 0 in IDLE, 1 in DONE so captured memory is kept.
                    IDLE, DONE: begin
                        if (arm_i) begin
                            state_q      <= ARMED;
                            s_enable_q   <= 1'b0;
                            triggered_q  <= 1'b0;
                            wait_count_q <= '0;
                            prev_match_q <= 1'b1;
                        end
                    end
                    ARMED: begin
                        wait_count_q <= wait_count_d;
                        prev_match_q <= match;
                        if (fire) begin
                            triggered_q <= 1'b1;
                            if (trig_delay_i == '0) begin
                                state_q    <= CAPTURE;
                                s_enable_q <= 1'b1;
                            end else begin
                                state_q     <= HOLDOFF;
                                delay_cnt_q <= trig_delay_i;
                            end
                        end
                    end
                    HOLDOFF: begin
                        delay_cnt_q <= delay_cnt_q - delayBits'(1);
                        if (delay_cnt_q <= delayBits'(1)) begin
                            state_q    <= CAPTURE;
                            s_enable_q <= 1'b1;
                        end
                    end
                    CAPTURE: begin
                        if (s_done_i) begin
                            state_q      <= DONE;
                            done_pulse_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q    <= IDLE;
                        s_enable_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign s_enable_o   = s_enable_q;
    assign state_o      = state_q;
    assign triggered_o  = triggered_q;
    assign done_pulse_o = done_pulse_q;
    assign wait_count_o = wait_count_q;

endmodule

// File: tb/tb_sampler_trigger.sv
// Directed bench for sampler_trigger: hand-computed expectations for each clocked step.
module tb_sampler_trigger;

    localparam int S_IDLE    = 0;
    localparam int S_ARMED   = 1;
    localparam int S_HOLDOFF = 2;
    localparam int S_CAPTURE = 3;
    localparam int S_DONE    = 4;

    logic        w_clk = 1'b0;
    logic        w_reset_n;
    logic [31:0] w_in;
    logic        arm;
    logic        abort_in;
    logic        force_in;
    logic [31:0] trig_mask;
    logic [31:0] trig_value;
    logic        trig_edge;
    logic [15:0] trig_delay;
    logic        s_done;
    logic        s_enable;
    logic [2:0]  state;
    logic        triggered;
    logic        done_pulse;
    logic [31:0] wait_count;

    int tests_run    = 0;
    int tests_failed = 0;

    sampler_trigger #(.width(32), .delayBits(16)) dut (
        .w_clk        (w_clk),
        .w_reset_n    (w_reset_n),
        .w_in_i       (w_in),
        .arm_i        (arm),
        .abort_i      (abort_in),
        .force_i      (force_in),
        .trig_mask_i  (trig_mask),
        .trig_value_i (trig_value),
        .trig_edge_i  (trig_edge),
        .trig_delay_i (trig_delay),
        .s_done_i     (s_done),
        .s_enable_o   (s_enable),
        .state_o      (state),
        .triggered_o  (triggered),
        .done_pulse_o (done_pulse),
        .wait_count_o (wait_count)
    );

    always #5 w_clk = ~w_clk;

    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_outs(input string tag, input int st, input logic en, input logic trg,
                              input logic dp);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".s_enable"}, 32'(s_enable), 32'(en));
        check({tag, ".triggered"}, 32'(triggered), 32'(trg));
        check({tag, ".done_pulse"}, 32'(done_pulse), 32'(dp));
    endtask

    initial begin
        w_reset_n  = 1'b0;
        w_in       = '0;
        arm        = 1'b1;
        abort_in   = 1'b0;
        force_in   = 1'b1;
        trig_mask  = 32'h0000_00FF;
        trig_value = 32'h0000_005A;
        trig_edge  = 1'b0;
        trig_delay = '0;
        s_done     = 1'b0;

        // Reset with arm/force asserted must still land in IDLE.
        step();
        step();
        check_outs("reset", S_IDLE, 1'b0, 1'b0, 1'b0);
        check("reset.wait_count", wait_count, 32'd0);
        arm      = 1'b0;
        force_in = 1'b0;
        w_reset_n = 1'b1;

        // Level trigger: 7 non-matching ARMED cycles, then match.
        arm = 1'b1;
        step();
        check_outs("lvl.armed", S_ARMED, 1'b0, 1'b0, 1'b0);
        check("lvl.wc0", wait_count, 32'd0);
        arm = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("lvl.wc7", wait_count, 32'd7);
        check_outs("lvl.still_armed", S_ARMED, 1'b0, 1'b0, 1'b0);
        w_in = 32'h0000_005A;
        step();
        check_outs("lvl.fire", S_CAPTURE, 1'b1, 1'b1, 1'b0);
        check("lvl.wc8", wait_count, 32'd8);

        // arm ignored in CAPTURE.
        arm = 1'b1;
        step();
        check_outs("cap.arm_ignored", S_CAPTURE, 1'b1, 1'b1, 1'b0);
        arm = 1'b0;

        // Completion: single-cycle done_pulse even with s_done held.
        s_done = 1'b1;
        step();
        check_outs("done.enter", S_DONE, 1'b1, 1'b1, 1'b1);
        step();
        check_outs("done.hold", S_DONE, 1'b1, 1'b1, 1'b0);
        s_done = 1'b0;

        // Re-arm from DONE.
        w_in = '0;
        arm  = 1'b1;
        step();
        check_outs("rearm", S_ARMED, 1'b0, 1'b0, 1'b0);
        check("rearm.wc", wait_count, 32'd0);
        arm = 1'b0;

        // Delay of 3: three HOLDOFF cycles, then CAPTURE.
        trig_delay = 16'd3;
        w_in       = 32'h0000_005A;
        step();
        check_outs("dly.t1", S_HOLDOFF, 1'b0, 1'b1, 1'b0);
        check("dly.wc", wait_count, 32'd1);
        w_in = '0;
        step();
        check_outs("dly.t2", S_HOLDOFF, 1'b0, 1'b1, 1'b0);
        step();
        check_outs("dly.t3", S_HOLDOFF, 1'b0, 1'b1, 1'b0);
        step();
        check_outs("dly.t4", S_CAPTURE, 1'b1, 1'b1, 1'b0);

        // Abort in HOLDOFF wins over arm and force; triggered is kept.
        s_done = 1'b1;
        step();
        s_done = 1'b0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        trig_delay = 16'd5;
        w_in = 32'h0000_005A;
        step();
        check_outs("abort.pre", S_HOLDOFF, 1'b0, 1'b1, 1'b0);
        abort_in = 1'b1;
        arm      = 1'b1;
        force_in = 1'b1;
        step();
        check_outs("abort", S_IDLE, 1'b0, 1'b1, 1'b0);
        abort_in = 1'b0;
        arm      = 1'b0;
        step();
        check_outs("idle.force", S_IDLE, 1'b0, 1'b1, 1'b0);
        force_in = 1'b0;

        // Edge mode: match present at arm must not fire until it falls and rises.
        trig_edge  = 1'b1;
        trig_delay = '0;
        w_in       = 32'h0000_005A;
        arm        = 1'b1;
        step();
        check_outs("edge.armed", S_ARMED, 1'b0, 1'b0, 1'b0);
        arm = 1'b0;
        step();
        step();
        check_outs("edge.nofire", S_ARMED, 1'b0, 1'b0, 1'b0);
        w_in = 32'h0000_0000;
        step();
        check_outs("edge.low", S_ARMED, 1'b0, 1'b0, 1'b0);
        w_in = 32'h0000_005A;
        step();
        check_outs("edge.fire", S_CAPTURE, 1'b1, 1'b1, 1'b0);
        check("edge.wc", wait_count, 32'd4);

        // Mask of zero, level mode: fires on the first ARMED cycle.
        abort_in = 1'b1;
        step();
        abort_in  = 1'b0;
        trig_mask = '0;
        trig_edge = 1'b0;
        w_in      = 32'h0000_0012;
        arm       = 1'b1;
        step();
        arm = 1'b0;
        step();
        check_outs("mask0.lvl", S_CAPTURE, 1'b1, 1'b1, 1'b0);
        check("mask0.lvl.wc", wait_count, 32'd1);

        // Mask of zero, edge mode: only force can fire.
        abort_in = 1'b1;
        step();
        abort_in  = 1'b0;
        trig_edge = 1'b1;
        arm       = 1'b1;
        step();
        arm = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check_outs("mask0.edge.wait", S_ARMED, 1'b0, 1'b0, 1'b0);
        check("mask0.edge.wc", wait_count, 32'd3);
        force_in = 1'b1;
        step();
        force_in = 1'b0;
        check_outs("mask0.edge.force", S_CAPTURE, 1'b1, 1'b1, 1'b0);

        // Reset during CAPTURE clears everything.
        w_reset_n = 1'b0;
        step();
        check_outs("rst.cap", S_IDLE, 1'b0, 1'b0, 1'b0);
        check("rst.cap.wc", wait_count, 32'd0);
        w_reset_n = 1'b1;
        step();
        check_outs("rst.after", S_IDLE, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
